// File: rtl/sync_fifo_nbit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sync_fifo_nbit                                             |
// | Description : Parametrised single-clock FIFO. Register-array storage     |
// |               with read/write pointers and an occupancy counter. All     |
// |               status flags are decoded from the registered count.        |
// | Ports       : clk, reset_n (async, active-low)                           |
// |               wr_en, wr_data          - write request / data             |
// |               rd_en, rd_data, rd_valid- read request / registered data   |
// |               full, empty, almost_full, almost_empty, count - status     |
// |               err_clr, overflow, underflow - only when the macro         |
// |               FIFO_ERR_FLAG_EN is defined (sticky drop indicators)       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sync_fifo_nbit #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AFULL_TH  = 12,
   parameter int AEMPTY_TH = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      wr_en,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic                      rd_en,
   output logic [WIDTH-1:0]          rd_data,
   output logic                      rd_valid,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [$clog2(DEPTH):0]    count
`ifdef FIFO_ERR_FLAG_EN
   ,
   input  logic                      err_clr,
   output logic                      overflow,
   output logic                      underflow
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
   localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_TH);
   localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_TH);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q,  count_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             rd_acc, wr_acc;

   // Flags come straight from the registered count, so they never glitch
   // when a read and a write land in the same cycle.
   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AFULL_C);
   assign almost_empty = (count_q <= AEMPTY_C);
   assign count        = count_q;
   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;

   always_comb begin
      // An empty FIFO rejects reads even with a same-cycle write (no
      // fall-through). A full FIFO still accepts a write when a read frees
      // a slot in the same cycle.
      rd_acc     = rd_en & ~empty;
      wr_acc     = wr_en & (~full | rd_acc);

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_acc;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
         rd_ptr_d  = rd_ptr_q + AW'(1);
         rd_data_d = mem_q[rd_ptr_q];
      end

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Storage is deliberately left out of reset; stale entries are never
   // visible because reads are gated by the count.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

`ifdef FIFO_ERR_FLAG_EN
   logic overflow_q,  overflow_d;
   logic underflow_q, underflow_d;

   // A set event in the same cycle as err_clr wins.
   always_comb begin
      overflow_d  = (overflow_q  & ~err_clr) | (wr_en & ~wr_acc);
      underflow_d = (underflow_q & ~err_clr) | (rd_en & empty);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_nbit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sync_fifo_nbit                                          |
// | Description : Self-checking bench for sync_fifo_nbit (WIDTH=8, DEPTH=16) |
// |               with a queue-based reference model.                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sync_fifo_nbit;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic       rd_en = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid, full, empty, almost_full, almost_empty;
   logic [4:0] count;
`ifdef FIFO_ERR_FLAG_EN
   logic       err_clr = 1'b0;
   logic       overflow, underflow;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: contents as a queue plus the expected registered outputs.
   logic [7:0] q[$];
   logic [7:0] m_rd_data  = '0;
   logic       m_rd_valid = 1'b0;
   logic       m_ovf      = 1'b0;
   logic       m_udf      = 1'b0;

   sync_fifo_nbit #(.WIDTH(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(2)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count)
`ifdef FIFO_ERR_FLAG_EN
      ,
      .err_clr      (err_clr),
      .overflow     (overflow),
      .underflow    (underflow)
`endif
   );

   always #5 clk = ~clk;

   // One clock cycle of stimulus; the model advances at the same edge and
   // outputs are then sampled 1 time unit later.
   task automatic cycle(input logic we, input logic [7:0] wd, input logic re, input logic clr);
      bit racc, wacc;
      wr_en = we; wr_data = wd; rd_en = re;
`ifdef FIFO_ERR_FLAG_EN
      err_clr = clr;
`endif
      @(posedge clk);
      racc = re && (q.size() > 0);
      wacc = we && ((q.size() < 16) || racc);
      m_ovf = (m_ovf && !clr) || (we && !wacc);
      m_udf = (m_udf && !clr) || (re && (q.size() == 0));
      m_rd_valid = racc;
      if (racc) m_rd_data = q.pop_front();
      if (wacc) q.push_back(wd);
      #1;
      wr_en = 1'b0; rd_en = 1'b0;
`ifdef FIFO_ERR_FLAG_EN
      err_clr = 1'b0;
`endif
   endtask

   task automatic model_reset();
      q.delete();
      m_rd_data = '0; m_rd_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
      n_cmp++; if ({full, empty, almost_full, almost_empty} !== 4'b0101) begin n_err++;
         $display("FAIL reset_flags: got %b expected 0101", {full, empty, almost_full, almost_empty}); end
      n_cmp++; if ({rd_valid, rd_data} !== 9'h000) begin n_err++;
         $display("FAIL reset_rd: got %h expected 000", {rd_valid, rd_data}); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         cycle(1'b1, 8'(i), 1'b0, 1'b0);
         n_cmp++; if (count !== 5'(i + 1)) begin n_err++;
            $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1); end
         n_cmp++; if (almost_full !== (i + 1 >= 12)) begin n_err++;
            $display("FAIL fill_afull[%0d]: got %b expected %b", i, almost_full, (i + 1 >= 12)); end
         n_cmp++; if (full !== (i == 15)) begin n_err++;
            $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i == 15)); end
      end
   endtask

   task automatic test_overflow();
      cycle(1'b1, 8'hAA, 1'b0, 1'b0);
      n_cmp++; if (count !== 5'd16 || full !== 1'b1) begin n_err++;
         $display("FAIL ovf_count: got %0d/%b expected 16/1", count, full); end
`ifdef FIFO_ERR_FLAG_EN
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
`endif
   endtask

   task automatic test_full_rw();
      logic [7:0] exp_w;
      cycle(1'b1, 8'h55, 1'b1, 1'b0);
      n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin n_err++;
         $display("FAIL fullrw_rd: got %b/%h expected 1/00", rd_valid, rd_data); end
      n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL fullrw_count: got %0d expected 16", count); end
      // Drain: 0x01..0x0F then 0x55; 0xAA must never appear.
      for (int i = 1; i <= 16; i++) begin
         exp_w = (i == 16) ? 8'h55 : 8'(i);
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
         n_cmp++; if (rd_valid !== 1'b1 || rd_data !== exp_w) begin n_err++;
            $display("FAIL drain[%0d]: got %b/%h expected 1/%h", i, rd_valid, rd_data, exp_w); end
      end
      n_cmp++; if (count !== 5'd0 || empty !== 1'b1) begin n_err++;
         $display("FAIL drain_end: got %0d/%b expected 0/1", count, empty); end
   endtask

   task automatic test_err_flags();
`ifdef FIFO_ERR_FLAG_EN
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      n_cmp++; if (underflow !== 1'b1 || overflow !== 1'b1) begin n_err++;
         $display("FAIL udf_set: got %b%b expected 11", overflow, underflow); end
      cycle(1'b0, 8'h00, 1'b1, 1'b1);
      n_cmp++; if (underflow !== 1'b1 || overflow !== 1'b0) begin n_err++;
         $display("FAIL clr_setwins: got %b%b expected 01", overflow, underflow); end
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      n_cmp++; if (underflow !== 1'b0 || overflow !== 1'b0) begin n_err++;
         $display("FAIL clr: got %b%b expected 00", overflow, underflow); end
`else
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      n_cmp++; if (rd_valid !== 1'b0 || count !== 5'd0 || rd_data !== 8'h55) begin n_err++;
         $display("FAIL empty_read: got %b/%0d/%h expected 0/0/55", rd_valid, count, rd_data); end
`endif
   endtask

   task automatic test_empty_rw();
      cycle(1'b1, 8'h33, 1'b1, 1'b0);
      n_cmp++; if (rd_valid !== 1'b0 || count !== 5'd1 || empty !== 1'b0) begin n_err++;
         $display("FAIL emptyrw: got %b/%0d/%b expected 0/1/0", rd_valid, count, empty); end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h33 || count !== 5'd0) begin n_err++;
         $display("FAIL emptyrw_rd: got %b/%h/%0d expected 1/33/0", rd_valid, rd_data, count); end
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 8'h33) begin n_err++;
         $display("FAIL hold: got %b/%h expected 0/33", rd_valid, rd_data); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 24; i++) begin
         cycle(i < 20, 8'($urandom), i >= 4, 1'b0);
         n_cmp++; if (rd_valid !== m_rd_valid || rd_data !== m_rd_data) begin n_err++;
            $display("FAIL wrap[%0d]: got %b/%h expected %b/%h", i, rd_valid, rd_data, m_rd_valid, m_rd_data); end
      end
      n_cmp++; if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin n_err++;
         $display("FAIL wrap_end: got %0d/%b/%b expected 0/1/1", count, empty, almost_empty); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      n_cmp++; if (count !== 5'd7 || rd_data !== 8'h10) begin n_err++;
         $display("FAIL pre_rst: got %0d/%h expected 7/10", count, rd_data); end
      #3 reset_n = 1'b0;
      #1;
      model_reset();
      n_cmp++; if (count !== 5'd0 || {full, empty, almost_full, almost_empty} !== 4'b0101) begin n_err++;
         $display("FAIL arst_flags: got %0d/%b expected 0/0101", count, {full, empty, almost_full, almost_empty}); end
      n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin n_err++;
         $display("FAIL arst_rd: got %b/%h expected 0/00", rd_valid, rd_data); end
      @(negedge clk) reset_n = 1'b1;
      cycle(1'b1, 8'h77, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h77 || count !== 5'd0) begin n_err++;
         $display("FAIL arst_after: got %b/%h/%0d expected 1/77/0", rd_valid, rd_data, count); end
   endtask

   task automatic test_random();
      int pw, pr, n;
      for (int i = 0; i < 400; i++) begin
         pw = ((i / 100) % 2 == 0) ? 80 : 25;
         pr = ((i / 100) % 2 == 0) ? 30 : 85;
         cycle($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
               $urandom_range(0, 99) < 10);
         n = q.size();
         n_cmp++; if (count !== 5'(n) || full !== (n == 16) || empty !== (n == 0) ||
                      almost_full !== (n >= 12) || almost_empty !== (n <= 2)) begin n_err++;
            $display("FAIL rnd_status[%0d]: got %0d/%b%b%b%b expected %0d", i, count,
                     full, empty, almost_full, almost_empty, n); end
         n_cmp++; if (rd_valid !== m_rd_valid || rd_data !== m_rd_data) begin n_err++;
            $display("FAIL rnd_rd[%0d]: got %b/%h expected %b/%h", i, rd_valid, rd_data, m_rd_valid, m_rd_data); end
`ifdef FIFO_ERR_FLAG_EN
         n_cmp++; if (overflow !== m_ovf || underflow !== m_udf) begin n_err++;
            $display("FAIL rnd_err[%0d]: got %b%b expected %b%b", i, overflow, underflow, m_ovf, m_udf); end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_full_rw();
      test_err_flags();
      test_empty_rw();
      test_wrap();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
